// File: rtl/dco_lock_ctrl_if.sv
// dco_lock_ctrl_if: reference input, acquisition handshake and DCO code bus
// of the DCO frequency-lock controller. The controller takes the slave side;
// whoever drives the reference and issues start takes the master side.
`timescale 1ps/1ps
interface dco_lock_ctrl_if #(
    parameter int ALPHA_W = 7,
    parameter int CNT_W   = 12
);
    logic               ref_in;
    logic               start;
    logic [CNT_W-1:0]   target_cnt;
    logic [ALPHA_W-1:0] alpha;
    logic               busy;
    logic               locked;
    logic [CNT_W-1:0]   meas_cnt;

    modport master (
        output ref_in, start, target_cnt,
        input  alpha, busy, locked, meas_cnt
    );

    modport slave (
        input  ref_in, start, target_cnt,
        output alpha, busy, locked, meas_cnt
    );
endinterface

// File: rtl/dco_lock_ctrl.sv
// dco_lock_ctrl: frequency-lock controller for a DCO, clocked by the DCO
// itself. It counts DCO cycles per reference period and runs a binary (SAR)
// search on the delay code alpha until the count matches the captured target.
// Larger alpha means more delay, i.e. a slower DCO and a smaller count.
// Optional feature macro: DCO_LOCK_TRACK_EN -- after the SAR search, keep
// tracking with +/-1 alpha steps and report lock only inside the deadband.
`timescale 1ps/1ps
module dco_lock_ctrl #(
    parameter int ALPHA_W     = 7,
    parameter int CNT_W       = 12,
    parameter int SETTLE_REFS = 1,
    parameter int LOCK_TOL    = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    dco_lock_ctrl_if.slave bus
);

    localparam int KW = (ALPHA_W > 1) ? $clog2(ALPHA_W) : 1;
    localparam int SW = $clog2(SETTLE_REFS + 2);

    localparam logic [KW-1:0]      K_TOP       = KW'(ALPHA_W - 1);
    localparam logic [KW-1:0]      K_ZERO      = KW'(0);
    localparam logic [KW-1:0]      K_ONE       = KW'(1);
    localparam logic [SW-1:0]      S_ZERO      = SW'(0);
    localparam logic [SW-1:0]      S_ONE       = SW'(1);
    localparam logic [SW-1:0]      SETTLE_LAST = SW'(SETTLE_REFS);
    localparam logic [CNT_W-1:0]   CNT_ZERO    = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [ALPHA_W-1:0] ALPHA_ZERO  = ALPHA_W'(0);
    localparam logic [ALPHA_W-1:0] ALPHA_ONE   = ALPHA_W'(1);

    // Parameter sets the counters cannot represent are rejected at elaboration.
    if ((LOCK_TOL < 0) || (LOCK_TOL >= (1 << CNT_W)) || (SETTLE_REFS < 0)) begin : g_param_err
        $error("dco_lock_ctrl: LOCK_TOL or SETTLE_REFS out of range");
    end

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_TRIAL   = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_MEASURE = 3'd3,
        ST_DECIDE  = 3'd4,
        ST_DONE    = 3'd5
`ifdef DCO_LOCK_TRACK_EN
        ,
        ST_TRACK   = 3'd6,
        ST_TSETTLE = 3'd7
`endif
    } state_t;

    // Saturating up-count used by the period counter.
    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == CNT_MAX) begin
            r = v;
        end else begin
            r = v + CNT_ONE;
        end
        return r;
    endfunction

`ifdef DCO_LOCK_TRACK_EN
    // Alpha step towards more delay, sticking at the top code.
    function automatic logic [ALPHA_W-1:0] alpha_sat_inc(input logic [ALPHA_W-1:0] v);
        logic [ALPHA_W-1:0] r;
        if (v == {ALPHA_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + ALPHA_ONE;
        end
        return r;
    endfunction

    // Alpha step towards less delay, sticking at zero.
    function automatic logic [ALPHA_W-1:0] alpha_sat_dec(input logic [ALPHA_W-1:0] v);
        logic [ALPHA_W-1:0] r;
        if (v == ALPHA_ZERO) begin
            r = v;
        end else begin
            r = v - ALPHA_ONE;
        end
        return r;
    endfunction
`endif

    // Reference synchroniser and edge detector state.
    logic               ref_s1_q;
    logic               ref_s2_q;
    logic               ref_s3_q;
    logic               ref_rise_s;

    // Period counter and measurement.
    logic [CNT_W-1:0]   run_cnt_q;
    logic [CNT_W-1:0]   run_cnt_d;
    logic [CNT_W-1:0]   meas_cnt_q;
    logic               meas_valid_q;

    // Acquisition FSM state and registered outputs.
    state_t             state_q;
    logic [ALPHA_W-1:0] alpha_q;
    logic               busy_q;
    logic               locked_q;
    logic [KW-1:0]      bit_q;
    logic [SW-1:0]      settle_q;
    logic [CNT_W-1:0]   target_q;

    logic [ALPHA_W-1:0] bit_mask_s;
    logic               meas_ge_s;
    logic               start_ok_s;

    // ref_in is asynchronous: two flops for metastability, a third to find the rising edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ref_s1_q <= 1'b0;
            ref_s2_q <= 1'b0;
            ref_s3_q <= 1'b0;
        end else begin
            ref_s1_q <= bus.ref_in;
            ref_s2_q <= ref_s1_q;
            ref_s3_q <= ref_s2_q;
        end
    end

    assign ref_rise_s = ref_s2_q & ~ref_s3_q;

    // Period counter restarts at 1 on each reference edge and otherwise counts up, never wrapping.
    always_comb begin
        run_cnt_d = run_cnt_q;
        if (ref_rise_s) begin
            run_cnt_d = CNT_ONE;
        end else begin
            run_cnt_d = cnt_sat_inc(run_cnt_q);
        end
    end

    // The count reached at a reference edge is the DCO cycles in the period just ended.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q    <= CNT_ZERO;
            meas_cnt_q   <= CNT_ZERO;
            meas_valid_q <= 1'b0;
        end else begin
            run_cnt_q    <= run_cnt_d;
            meas_valid_q <= ref_rise_s;
            if (ref_rise_s) begin
                meas_cnt_q <= run_cnt_q;
            end
        end
    end

    assign bit_mask_s = ALPHA_ONE << bit_q;
    // Count at or above target: DCO is fast enough or on target, so the trial bit stays.
    assign meas_ge_s  = (meas_cnt_q >= target_q);

`ifdef DCO_LOCK_TRACK_EN
    localparam int TW = CNT_W + 1;
    localparam logic [TW-1:0] TOL_X = TW'(LOCK_TOL);

    logic [TW-1:0]    hi_lim_s;
    logic [CNT_W-1:0] lo_lim_s;
    logic             above_s;
    logic             below_s;

    // One extra bit keeps target+tol from wrapping; target-tol clamps at zero.
    assign hi_lim_s = {1'b0, target_q} + TOL_X;
    assign lo_lim_s = ({1'b0, target_q} < TOL_X) ? CNT_ZERO : (target_q - TOL_X[CNT_W-1:0]);
    assign above_s  = ({1'b0, meas_cnt_q} > hi_lim_s);
    assign below_s  = (meas_cnt_q < lo_lim_s);
`endif

    // A start is honoured only when no search is running.
    always_comb begin
        start_ok_s = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE: start_ok_s = bus.start;
`ifdef DCO_LOCK_TRACK_EN
            ST_TRACK, ST_TSETTLE: start_ok_s = bus.start;
`endif
            default: start_ok_s = 1'b0;
        endcase
    end

    // Acquisition FSM: SAR from the MSB down, each step settles then measures once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            alpha_q  <= ALPHA_ZERO;
            busy_q   <= 1'b0;
            locked_q <= 1'b0;
            bit_q    <= K_ZERO;
            settle_q <= S_ZERO;
            target_q <= CNT_ZERO;
        end else if (start_ok_s) begin
            // Start also wins over a simultaneous reference edge; settling discards that period.
            target_q <= bus.target_cnt;
            bit_q    <= K_TOP;
            alpha_q  <= ALPHA_ZERO;
            busy_q   <= 1'b1;
            locked_q <= 1'b0;
            settle_q <= S_ZERO;
            state_q  <= ST_TRIAL;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_TRIAL: begin
                    alpha_q  <= alpha_q | bit_mask_s;
                    settle_q <= S_ZERO;
                    state_q  <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    // First pulse closes the partial period, then SETTLE_REFS full ones are dropped.
                    if (meas_valid_q) begin
                        if (settle_q == SETTLE_LAST) begin
                            settle_q <= S_ZERO;
                            state_q  <= ST_MEASURE;
                        end else begin
                            settle_q <= settle_q + S_ONE;
                        end
                    end
                end
                ST_MEASURE: begin
                    if (meas_valid_q) begin
                        state_q <= ST_DECIDE;
                    end
                end
                ST_DECIDE: begin
                    if (!meas_ge_s) begin
                        alpha_q <= alpha_q & ~bit_mask_s;
                    end
                    if (bit_q == K_ZERO) begin
                        busy_q   <= 1'b0;
                        locked_q <= 1'b1;
`ifdef DCO_LOCK_TRACK_EN
                        state_q  <= ST_TRACK;
`else
                        state_q  <= ST_DONE;
`endif
                    end else begin
                        bit_q   <= bit_q - K_ONE;
                        state_q <= ST_TRIAL;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
`ifdef DCO_LOCK_TRACK_EN
                ST_TRACK: begin
                    if (meas_valid_q) begin
                        if (above_s) begin
                            alpha_q  <= alpha_sat_inc(alpha_q);
                            locked_q <= 1'b0;
                            settle_q <= S_ZERO;
                            state_q  <= ST_TSETTLE;
                        end else if (below_s) begin
                            alpha_q  <= alpha_sat_dec(alpha_q);
                            locked_q <= 1'b0;
                            settle_q <= S_ZERO;
                            state_q  <= ST_TSETTLE;
                        end else begin
                            locked_q <= 1'b1;
                        end
                    end
                end
                ST_TSETTLE: begin
                    if (meas_valid_q) begin
                        if (settle_q == SETTLE_LAST) begin
                            settle_q <= S_ZERO;
                            state_q  <= ST_TRACK;
                        end else begin
                            settle_q <= settle_q + S_ONE;
                        end
                    end
                end
`endif
                default: begin
                    state_q  <= ST_IDLE;
                    alpha_q  <= ALPHA_ZERO;
                    busy_q   <= 1'b0;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alpha    = alpha_q;
    assign bus.busy     = busy_q;
    assign bus.locked   = locked_q;
    assign bus.meas_cnt = meas_cnt_q;

endmodule

// File: tb/tb_dco_lock_ctrl.sv
// Bench for dco_lock_ctrl. The DCO model period is 100ps + 4ps*alpha (+drift),
// the reference period is 40ns. Expected final codes are queued at each
// accepted start and compared when busy falls.
`timescale 1ps/1ps
module tb_dco_lock_ctrl;

    localparam int ALPHA_W = 7;
    localparam int CNT_W   = 12;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    bit   ref_en = 1'b0;
    int   drift_ps = 0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string tag;
        int    lo;
        int    hi;
    } sb_t;
    sb_t sb[$];

    dco_lock_ctrl_if #(.ALPHA_W(ALPHA_W), .CNT_W(CNT_W)) bus ();

    dco_lock_ctrl #(
        .ALPHA_W(ALPHA_W), .CNT_W(CNT_W), .SETTLE_REFS(1), .LOCK_TOL(1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // DCO model: half period follows the current alpha code.
    initial begin
        int half;
        forever begin
            if ($isunknown(bus.alpha)) half = 50;
            else half = (100 + 4 * int'(bus.alpha) + drift_ps) / 2;
            #(half) clk = ~clk;
        end
    end

    // Reference clock, 40ns period while enabled, held low otherwise.
    initial begin
        bus.ref_in = 1'b0;
        forever begin
            if (ref_en) begin
                bus.ref_in = 1'b1;
                #20000;
                bus.ref_in = 1'b0;
                #20000;
            end else begin
                bus.ref_in = 1'b0;
                #1000;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_range(input string tag, input logic [31:0] obs, input int lo, input int hi);
        logic in_rng;
        in_rng = (obs >= lo) && (obs <= hi);
        checks++;
        assert (in_rng === 1'b1) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
        end
    endtask

    // One-cycle start pulse; an accepted start queues the expected final alpha range.
    task automatic pulse_start(input int tgt, input bit accept, input string tag, input int lo, input int hi);
        sb_t e;
        @(posedge clk);
        #1;
        bus.target_cnt = CNT_W'(tgt);
        bus.start      = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        if (accept) begin
            e.tag = tag;
            e.lo  = lo;
            e.hi  = hi;
            sb.push_back(e);
            check({tag, "_busy1"},   bus.busy,   1);
            check({tag, "_alpha0"},  bus.alpha,  0);
            check({tag, "_locked0"}, bus.locked, 0);
        end else begin
            check({tag, "_ign_busy"}, bus.busy, 1);
        end
    endtask

    // Wait (bounded) for busy to fall, then pop and compare the queued expectation.
    task automatic wait_done();
        sb_t e;
        time t0;
        bit  to;
        t0 = $time;
        to = 1'b0;
        while ((bus.busy === 1'b1) && !to) begin
            @(negedge clk);
            if ($time - t0 > 64'd4_000_000) to = 1'b1;
        end
        check("done_timeout", 32'(to), 0);
        check("sb_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check_range(e.tag, bus.alpha, e.lo, e.hi);
            check({e.tag, "_locked"}, bus.locked, 1);
        end
    endtask

    initial begin
        time t0;
        bus.start      = 1'b0;
        bus.target_cnt = '0;
        rst_n          = 1'b0;
        ref_en         = 1'b1;

        // Reset held with clock and reference running.
        repeat (20) @(posedge clk);
        @(negedge clk);
        check("rst_alpha",  bus.alpha,    0);
        check("rst_busy",   bus.busy,     0);
        check("rst_locked", bus.locked,   0);
        check("rst_meas",   bus.meas_cnt, 0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Acquire at 80 (ideal alpha 100); a start with another target mid-search is ignored.
        pulse_start(80, 1'b1, "acq80", 99, 101);
        #300000;
        pulse_start(1, 1'b0, "mid_start", 0, 0);
        wait_done();

        // Restart from the locked state.
        pulse_start(80, 1'b1, "restart80", 99, 101);
        wait_done();

        // Reset in the middle of the search, then reacquire.
        pulse_start(80, 1'b1, "aborted", 99, 101);
        #300000;
        rst_n = 1'b0;
        #1;
        check("midrst_alpha",  bus.alpha,    0);
        check("midrst_busy",   bus.busy,     0);
        check("midrst_locked", bus.locked,   0);
        check("midrst_meas",   bus.meas_cnt, 0);
        sb.delete(sb.size() - 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        pulse_start(80, 1'b1, "reacq80", 99, 101);
        wait_done();

        // No reference edges: FSM waits in settle with the MSB trial, counter saturates.
        ref_en = 1'b0;
        #50000;
        pulse_start(4095, 1'b1, "tgt4095", 0, 0);
        #2500000;
        @(negedge clk);
        check("noref_busy",  bus.busy,  1);
        check("noref_alpha", bus.alpha, 64);
        ref_en = 1'b1;
        #12000;
        @(negedge clk);
        check("sat_meas", bus.meas_cnt, 4095);
        wait_done();

        // Smallest target drives every bit to one.
        pulse_start(1, 1'b1, "tgt1", 127, 127);
        wait_done();
        check_range("tgt1_meas_sane", bus.meas_cnt, 60, 70);

`ifdef DCO_LOCK_TRACK_EN
        // Tracking: lock at 80, then slow the DCO by 8ps; alpha must walk down into the band.
        pulse_start(80, 1'b1, "trk_acq80", 99, 101);
        wait_done();
        drift_ps = 8;
        t0 = $time;
        while ((bus.alpha > 7'd99) && ($time - t0 < 64'd6_000_000)) @(negedge clk);
        check_range("trk_step_down", bus.alpha, 97, 99);
        #1000000;
        @(negedge clk);
        check_range("trk_hold", bus.alpha, 97, 99);
        check("trk_locked", bus.locked, 1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
